// File: rtl/seg7_pkg.sv
// Shared constants and the BCD-to-segment decode table for the 4-digit scanned display.
// Segment vectors are always {g,f,e,d,c,b,a} in active-high form.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Nibbles above 9 are not BCD and are shown as a dash so corruption is visible.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] seg_v;
        case (nibble)
            4'd0:    seg_v = 7'h3F;
            4'd1:    seg_v = 7'h06;
            4'd2:    seg_v = 7'h5B;
            4'd3:    seg_v = 7'h4F;
            4'd4:    seg_v = 7'h66;
            4'd5:    seg_v = 7'h6D;
            4'd6:    seg_v = 7'h7D;
            4'd7:    seg_v = 7'h07;
            4'd8:    seg_v = 7'h7F;
            4'd9:    seg_v = 7'h6F;
            default: seg_v = SEG_DASH;
        endcase
        return seg_v;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder, active-high output.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup only; polarity is handled by the caller.
    always_comb begin
        seg = bcd_to_seg(nibble);
    end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Time-multiplexed 4-digit 7-segment driver for a packed BCD value, with a shadow
// register so the shown value only changes on frame boundaries.
module bcd_seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          LZ_BLANK       = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int              CNT_W   = (REFRESH_DIV > 32'd1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(REFRESH_DIV - 32'd1);

    localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF  : 4'h0;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;

    logic [CNT_W-1:0]      div_cnt_r;
    logic [1:0]            dig_idx_r;
    logic [15:0]           shadow_bcd_r;
    logic [3:0]            shadow_dp_r;
    logic [15:0]           disp_bcd_r;
    logic [3:0]            disp_dp_r;

    logic                  tick_s;
    logic                  frame_s;
    logic [3:0]            nibble_s;
    logic [6:0]            seg_dec_s;
    logic [NUM_DIGITS-1:0] lz_s;
    logic                  blank_s;
    logic [3:0]            an_hi_s;
    logic [6:0]            seg_hi_s;
    logic                  dp_hi_s;
    logic [3:0]            an_nxt_s;
    logic [6:0]            seg_nxt_s;
    logic                  dp_nxt_s;

    // Refresh tick and frame boundary (last digit's tick).
    always_comb begin
        tick_s  = (div_cnt_r == DIV_MAX);
        frame_s = tick_s && (dig_idx_r == 2'd3);
    end

    // Refresh divider and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= '0;
            dig_idx_r <= 2'd0;
        end else if (tick_s) begin
            div_cnt_r <= '0;
            dig_idx_r <= dig_idx_r + 2'd1;
        end else begin
            div_cnt_r <= div_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Shadow capture: the last load before a frame boundary wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_bcd_r <= 16'h0000;
            shadow_dp_r  <= 4'h0;
        end else if (load) begin
            shadow_bcd_r <= bcd_in;
            shadow_dp_r  <= dp_in;
        end
    end

    // Display buffer: takes the pre-edge shadow, so a load on the boundary waits a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_bcd_r <= 16'h0000;
            disp_dp_r  <= 4'h0;
        end else if (frame_s) begin
            disp_bcd_r <= shadow_bcd_r;
            disp_dp_r  <= shadow_dp_r;
        end
    end

    // Select the nibble of the digit currently being scanned.
    always_comb begin
        case (dig_idx_r)
            2'd0:    nibble_s = disp_bcd_r[3:0];
            2'd1:    nibble_s = disp_bcd_r[7:4];
            2'd2:    nibble_s = disp_bcd_r[11:8];
            2'd3:    nibble_s = disp_bcd_r[15:12];
            default: nibble_s = 4'h0;
        endcase
    end

    seg7_decode u_decode (
        .nibble (nibble_s),
        .seg    (seg_dec_s)
    );

    // lz_s[k]: digit k and all higher digits are zero; non-BCD nibbles count as non-zero.
    always_comb begin
        lz_s[3] = (disp_bcd_r[15:12] == 4'h0);
        lz_s[2] = (disp_bcd_r[11:8]  == 4'h0) && lz_s[3];
        lz_s[1] = (disp_bcd_r[7:4]   == 4'h0) && lz_s[2];
        lz_s[0] = (disp_bcd_r[3:0]   == 4'h0) && lz_s[1];
        if (LZ_BLANK && (dig_idx_r != 2'd0)) begin
            blank_s = lz_s[dig_idx_r];
        end else begin
            blank_s = 1'b0;
        end
    end

    // Active-high next outputs; the enable stays on even for a blanked digit.
    always_comb begin
        an_hi_s = 4'b0001 << dig_idx_r;
        if (blank_s) begin
            seg_hi_s = SEG_BLANK;
            dp_hi_s  = 1'b0;
        end else begin
            seg_hi_s = seg_dec_s;
            dp_hi_s  = disp_dp_r[dig_idx_r];
        end
    end

    // Apply output polarity.
    always_comb begin
        if (SEG_ACTIVE_LOW) begin
            an_nxt_s  = ~an_hi_s;
            seg_nxt_s = ~seg_hi_s;
            dp_nxt_s  = ~dp_hi_s;
        end else begin
            an_nxt_s  = an_hi_s;
            seg_nxt_s = seg_hi_s;
            dp_nxt_s  = dp_hi_s;
        end
    end

    // Output registers, one clock behind the digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= DP_OFF;
        end else begin
            an  <= an_nxt_s;
            seg <= seg_nxt_s;
            dp  <= dp_nxt_s;
        end
    end

endmodule
